// File: rtl/iir_sample_capture.sv
// Purpose: capture a programmed block of IIR output words into a buffer, then replay them in order.
// Latency: capture begins the cycle after start_i; in drain rd_valid_o rises 1 cycle after entering DRAIN.
// Backpressure: rd_valid_o/rd_data_o hold while rd_ready_i=0; input samples arriving in DRAIN are dropped (ovf_o).
module iir_sample_capture #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W:0]   n_samples_i,
  input  logic [N_BITS-1:0] y_i,
  input  logic              y_valid_i,
  output logic [N_BITS-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t state, state_nx;

  logic [N_BITS-1:0] mem [DEPTH];
  logic [N_BITS-1:0] ram_q;

  logic [ADDR_W:0]   target;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   n_clamp;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   rd_idx_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic              fire;
  logic              rd_last;
  logic              run_done;
  logic              zero_done;

  assign n_clamp    = (n_samples_i > DEPTH_C) ? DEPTH_C : n_samples_i;
  assign count_inc  = count_o + ONE_C;
  assign rd_idx_inc = rd_idx + ONE_C;
  assign fire       = rd_valid_o & rd_ready_i;
  assign rd_last    = (rd_idx == (target - ONE_C));

  // The RAM output register is only meaningful while a word is presented.
  assign rd_data_o  = rd_valid_o ? ram_q : '0;

  // Next state, write enable and read address lookahead (next word fetched on a transfer, so no bubbles).
  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    rd_addr   = rd_idx[ADDR_W-1:0];
    run_done  = 1'b0;
    zero_done = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (n_clamp == '0) zero_done = 1'b1;
          else               state_nx  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (y_valid_i) begin
          wr_en = 1'b1;
          if (count_inc == target) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (fire) begin
          if (rd_last) begin
            state_nx = IDLE;
            run_done = 1'b1;
          end else begin
            rd_addr = rd_idx_inc[ADDR_W-1:0];
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered busy/done status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_o <= (state_nx != IDLE);
      done_o <= run_done | zero_done;
    end
  end

  // Run bookkeeping: target latch, capture count, overflow flag and drain pointer/valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target     <= '0;
      count_o    <= '0;
      ovf_o      <= 1'b0;
      rd_idx     <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            target  <= n_clamp;
            count_o <= '0;
            ovf_o   <= 1'b0;
            rd_idx  <= '0;
          end
        end
        CAPTURE: begin
          if (y_valid_i) count_o <= count_inc;
        end
        DRAIN: begin
          if (y_valid_i) ovf_o <= 1'b1;
          if (!rd_valid_o) begin
            rd_valid_o <= 1'b1;
          end else if (fire) begin
            if (rd_last) rd_valid_o <= 1'b0;
            else         rd_idx     <= rd_idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Simple dual-port buffer: write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_o[ADDR_W-1:0]] <= y_i;
  end

  // Simple dual-port buffer: registered read port.
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_iir_sample_capture.sv
// Directed bench for iir_sample_capture: capture/replay, backpressure, limits, reset and ignored starts.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Drain waits are bounded; an expired bound counts as a failed comparison.
module tb_iir_sample_capture;
  localparam int N_BITS = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic [ADDR_W:0]   n_samples_i;
  logic [N_BITS-1:0] y_i;
  logic              y_valid_i;
  logic [N_BITS-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   count_o;
  logic              ovf_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] got[$];
  int ndone, first_vld, first_xfer, last_xfer;

  iir_sample_capture #(.N_BITS(N_BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .n_samples_i(n_samples_i),
    .y_i(y_i), .y_valid_i(y_valid_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [ADDR_W:0] n, input logic yv, input logic [31:0] y);
    start_i = 1'b1; n_samples_i = n; y_valid_i = yv; y_i = y;
    tick();
    start_i = 1'b0; y_valid_i = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w);
    y_i = w; y_valid_i = 1'b1;
    tick();
    y_valid_i = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles starting high.
  task automatic collect(input int mode, input int max_cyc);
    int cyc = 0;
    int post = -1;
    got.delete(); ndone = 0; first_vld = -1; first_xfer = -1; last_xfer = -1;
    while (cyc < max_cyc && post != 0) begin
      rd_ready_i = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (rd_valid_o && first_vld < 0) first_vld = cyc;
      if (rd_valid_o && rd_ready_i) begin
        got.push_back(rd_data_o);
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (done_o) begin
        ndone++;
        if (post < 0) post = 3;
      end
      if (post > 0) post--;
      tick();
      cyc++;
    end
    rd_ready_i = 1'b0;
    total++;
    if (ndone == 0) begin
      bad++;
      $display("FAIL drain_timeout: done_o not seen within %0d cycles (got %0d words)", max_cyc, got.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int w = 0;
    while (!rd_valid_o && w < 10) begin tick(); w++; end
    total++;
    if (rd_valid_o !== 1'b1) begin bad++; $display("FAIL %s_valid_wait: rd_valid_o=%b required 1", name, rd_valid_o); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 0; n_samples_i = '0; y_i = '0; y_valid_i = 0; rd_ready_i = 0;
    #2;
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid_o); end
    total++; if (rd_data_o !== 32'h0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (count_o !== 11'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_w [4];
    exp_w = '{32'h00004AFA, 32'hFFFF95F7, 32'h00000001, 32'h80000000};
    start_run(11'd4, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) feed(exp_w[i]);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    total++; if (count_o !== 11'd4) begin bad++; $display("FAIL basic_count_cap: got %0d want 4", count_o); end
    collect(0, 20);
    total++; if (got.size() != 4) begin bad++; $display("FAIL basic_nwords: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, got[i], exp_w[i]); end
      end
    end
    total++; if (last_xfer - first_xfer != 3) begin bad++; $display("FAIL basic_no_bubble: span %0d want 3", last_xfer - first_xfer); end
    total++; if (first_vld < 0 || first_vld > 2) begin bad++; $display("FAIL basic_valid_latency: got %0d want <=2", first_vld); end
    total++; if (ndone != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    total++; if (count_o !== 11'd4) begin bad++; $display("FAIL basic_count_hold: got %0d want 4", count_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ovf_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    exp_w = '{32'h11, 32'h22, 32'h33};
    start_run(11'd3, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) feed(exp_w[i]);
    rd_ready_i = 1'b0;
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rd_data_o !== 32'h11 || rd_valid_o !== 1'b1) begin
        bad++; $display("FAIL bp_stall%0d: data=%h valid=%b want 00000011/1", k, rd_data_o, rd_valid_o);
      end
      tick();
    end
    collect(1, 30);
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_nwords: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== exp_w[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got[i], exp_w[i]); end
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", ndone); end
  endtask

  task automatic test_gapped();
    start_run(11'd2, 1'b1, 32'hDEAD);
    tick(); tick();
    feed(32'h1);
    tick(); tick();
    feed(32'h2);
    total++; if (count_o !== 11'd2) begin bad++; $display("FAIL gap_count: got %0d want 2", count_o); end
    collect(0, 20);
    total++; if (got.size() != 2) begin bad++; $display("FAIL gap_nwords: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 32'h1) begin bad++; $display("FAIL gap_word0: got %h want 00000001", got[0]); end
      total++; if (got[1] !== 32'h2) begin bad++; $display("FAIL gap_word1: got %h want 00000002", got[1]); end
    end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL gap_ovf: got %b want 0", ovf_o); end
  endtask

  task automatic test_zero();
    start_run(11'd0, 1'b0, 32'h0);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy_o); end
    total++; if (count_o !== 11'd0) begin bad++; $display("FAIL zero_count: got %0d want 0", count_o); end
    tick();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_busy_after: got %b want 0", busy_o); end
  endtask

  task automatic test_clamp();
    int errs = 0;
    start_run(11'(DEPTH + 5), 1'b0, 32'h0);
    rd_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 5; i++) feed(32'(i));
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL clamp_ovf: got %b want 1", ovf_o); end
    total++; if (count_o !== 11'(DEPTH)) begin bad++; $display("FAIL clamp_count: got %0d want %0d", count_o, DEPTH); end
    collect(0, DEPTH + 20);
    total++; if (got.size() != DEPTH) begin bad++; $display("FAIL clamp_nwords: got %0d want %0d", got.size(), DEPTH); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== 32'(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL clamp_ramp: %0d wrong words, want 0", errs); end
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL clamp_ovf_sticky: got %b want 1", ovf_o); end
  endtask

  task automatic test_reset_mid();
    int dseen = 0;
    start_run(11'd8, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) feed(32'h100 + 32'(i));
    wait_valid("rst");
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data_o !== 32'h100 + 32'(i)) begin bad++; $display("FAIL rst_pre_word%0d: got %h want %h", i, rd_data_o, 32'h100 + 32'(i)); end
      tick();
    end
    reset = 1'b0;
    #1;
    total++; if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h0) begin bad++; $display("FAIL rst_mid_rd: valid=%b data=%h want 0/0", rd_valid_o, rd_data_o); end
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL rst_mid_status: busy=%b done=%b want 0/0", busy_o, done_o); end
    total++; if (count_o !== 11'd0 || ovf_o !== 1'b0) begin bad++; $display("FAIL rst_mid_count: count=%0d ovf=%b want 0/0", count_o, ovf_o); end
    rd_ready_i = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done_o) dseen++;
      tick();
    end
    total++; if (dseen != 0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_no_done: done pulses=%0d busy=%b want 0/0", dseen, busy_o); end
    start_run(11'd2, 1'b0, 32'h0);
    feed(32'hA);
    feed(32'hB);
    collect(0, 20);
    total++; if (got.size() != 2) begin bad++; $display("FAIL rst_rerun_nwords: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 32'hA) begin bad++; $display("FAIL rst_rerun_word0: got %h want 0000000a", got[0]); end
      total++; if (got[1] !== 32'hB) begin bad++; $display("FAIL rst_rerun_word1: got %h want 0000000b", got[1]); end
    end
  endtask

  task automatic test_ignored_start();
    start_run(11'd4, 1'b0, 32'h0);
    feed(32'h10);
    y_i = 32'h11; y_valid_i = 1'b1; start_i = 1'b1; n_samples_i = 11'd1;
    tick();
    y_valid_i = 1'b0; start_i = 1'b0;
    feed(32'h12);
    feed(32'h13);
    total++; if (count_o !== 11'd4 || busy_o !== 1'b1) begin bad++; $display("FAIL ign_capture: count=%0d busy=%b want 4/1", count_o, busy_o); end
    rd_ready_i = 1'b0;
    wait_valid("ign");
    start_i = 1'b1; n_samples_i = 11'd1;
    tick();
    start_i = 1'b0;
    total++; if (count_o !== 11'd4 || busy_o !== 1'b1 || rd_data_o !== 32'h10) begin
      bad++; $display("FAIL ign_drain: count=%0d busy=%b data=%h want 4/1/00000010", count_o, busy_o, rd_data_o);
    end
    collect(0, 20);
    total++; if (got.size() != 4) begin bad++; $display("FAIL ign_nwords: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== 32'h10 + 32'(i)) begin bad++; $display("FAIL ign_word%0d: got %h want %h", i, got[i], 32'h10 + 32'(i)); end
      end
    end
    total++; if (ndone != 1 || count_o !== 11'd4) begin bad++; $display("FAIL ign_end: done pulses=%0d count=%0d want 1/4", ndone, count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_zero();
    test_clamp();
    test_reset_mid();
    test_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_sample_capture.md
Name: iir_sample_capture

Overview:
- Sink end of the IIR sample stream: captures a programmed number of consecutive filter output words into an on-chip buffer.
- Once capture is complete, replays the words in capture order over a valid/ready read port.
- Lets silicon or FPGA runs dump filter response blocks without a simulator-side file writer.
- Sits after the IIR output register; its read port feeds the host/debug readout path.

Parameters:
- N_BITS, 32, width of one sample word (filter output width).
- DEPTH, 1024, buffer capacity in samples; must be a power of two ≥ 2.
- ADDR_W, 10, log2(DEPTH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle pulse; arms a capture run (honoured only in IDLE).
- n_samples_i  input  ADDR_W+1  samples to capture; sampled on the start_i cycle.
- y_i  input  N_BITS  filter output word.
- y_valid_i  input  1  y_i is a new sample this cycle.
- rd_data_o  output  N_BITS  replayed sample.
- rd_valid_o  output  1  rd_data_o holds a valid sample.
- rd_ready_i  input  1  consumer accepts rd_data_o this cycle.
- busy_o  output  1  high in CAPTURE or DRAIN.
- done_o  output  1  one-cycle pulse at end of run.
- count_o  output  ADDR_W+1  samples captured in the current run.
- ovf_o  output  1  sticky: a y_valid_i sample was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - rd_data_o=0, rd_valid_o=0, busy_o=0, done_o=0, count_o=0, ovf_o=0.
  - Write/read pointers cleared. Buffer contents undefined.
  - Reset asserted mid-run aborts the run; no done_o is produced.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - On start_i: latch target = min(n_samples_i, DEPTH), clear count_o and ovf_o, go to CAPTURE.
  - If target = 0: go straight to IDLE instead, with done_o pulsed the next cycle.
  - y_valid_i in IDLE is ignored and does not set ovf_o.
- CAPTURE:
  - Capture begins the cycle after start_i; a y_valid_i coincident with start_i is not stored.
  - Each y_valid_i cycle writes y_i at the write pointer, then increments the pointer and count_o.
  - When count_o reaches target (on the write edge), go to DRAIN.
  - start_i is ignored.
- DRAIN:
  - Buffer read is registered, 1-cycle latency.
  - rd_valid_o rises no later than 2 cycles after entering DRAIN.
  - Words are presented in capture order, index 0 to target-1.
  - A transfer occurs when rd_valid_o & rd_ready_i.
  - While rd_valid_o=1 and rd_ready_i=0, rd_data_o and rd_valid_o hold stable.
  - With rd_ready_i held at 1, one word transfers per cycle after the first (prefetch/skid required; no bubbles).
  - After the transfer of word target-1: rd_valid_o=0 next cycle, done_o=1 for one cycle, go to IDLE.
  - y_valid_i in DRAIN: the sample is dropped and ovf_o=1 (sticky until the next accepted start_i).
- Status outputs:
  - busy_o is registered and equals (state != IDLE).
  - count_o holds its final value after the run until the next accepted start_i.
- Width rules:
  - Pointers are ADDR_W bits; count/target are ADDR_W+1 bits so DEPTH itself is representable.
  - No wrap within a run: capture stops exactly at target.
  - n_samples_i > DEPTH is clamped to DEPTH.
- Buffer is an inferable single-clock simple dual-port RAM (one write port, one registered read port).

Test Plan:
- Basic run: reset, start_i with n_samples_i=4, feed y_i=0x00004AFA, 0xFFFF95F7, 0x00000001, 0x80000000 on consecutive y_valid_i cycles, rd_ready_i=1 → exactly those 4 words in order on consecutive handshake cycles; done_o pulses once; count_o=4; ovf_o=0.
- Backpressure: capture 3 samples 0x11, 0x22, 0x33; hold rd_ready_i=0 for 5 cycles after rd_valid_o rises, then toggle 1/0 → rd_data_o stays 0x11 while stalled; each word is transferred exactly once in order.
- Gapped input plus coincident start: y_valid_i asserted on the start_i cycle with 0xDEAD, then every third cycle with 0x1, 0x2 (n_samples_i=2) → 0xDEAD is not captured; output is 0x1, 0x2.
- Limits: n_samples_i=0 → done_o pulses the next cycle, busy_o never rises. n_samples_i=DEPTH+5 with ramp data 0..DEPTH+4 → exactly DEPTH words 0..DEPTH-1 are drained; the extra 5 samples, arriving during DRAIN, set ovf_o=1.
- Reset mid-run: assert reset low for 1 cycle halfway through DRAIN of an 8-sample run → all outputs return to reset values immediately and no done_o is produced. A new run with n_samples_i=2 (0xA, 0xB) then drains 0xA, 0xB correctly.
- Ignored start: pulse start_i during CAPTURE and during DRAIN of a 4-sample run → no restart, count_o unaffected, a single done_o at the end.
